// File: rtl/gun_position_ctrl.sv
// Joystick/mouse to 6-bit light-gun coordinate converter for the williams2 core.
// Positions are held in 6.4 fixed point, paced by the core's 4 ms tick, with hold acceleration.
module gun_position_ctrl #(
    parameter int unsigned ACCEL_TICKS = 32,
    parameter int unsigned MOUSE_SHIFT = 3
) (
    input  logic              clock_12,
    input  logic              reset_n,
    input  logic              tick_in,
    input  logic              left,
    input  logic              right,
    input  logic              up,
    input  logic              down,
    input  logic              recenter,
    input  logic              mouse_strobe,
    input  logic signed [8:0] mouse_dx,
    input  logic signed [8:0] mouse_dy,
    output logic [5:0]        gun_h,
    output logic [5:0]        gun_v,
    output logic              moving
);

    typedef enum logic [1:0] {StIdle, StSlow, StFast} axis_state_e;

    localparam logic [9:0]         PosCentre = 10'd512;
    localparam logic [7:0]         AccelCnt  = 8'(ACCEL_TICKS);
    localparam logic signed [11:0] StepSlow  = 12'sd4;
    localparam logic signed [11:0] StepFast  = 12'sd16;

    axis_state_e        state_q [2];
    axis_state_e        state_d [2];
    logic [7:0]         cnt_q   [2];
    logic [7:0]         cnt_d   [2];
    logic               dir_q   [2];
    logic               dir_d   [2];
    logic [9:0]         pos_q   [2];
    logic [9:0]         pos_d   [2];
    logic signed [11:0] step    [2];
    logic signed [11:0] sum     [2];
    logic signed [11:0] mdelta  [2];
    logic               tick_prev_q;
    logic               moving_q;
    logic               moving_d;
    logic               tick;
    logic [1:0]         dir_neg;
    logic [1:0]         dir_pos;
    logic [1:0]         single;
    logic signed [8:0]  dx_sh;
    logic signed [8:0]  dy_sh;

    assign tick    = tick_in & ~tick_prev_q;
    assign dir_neg = {up, left};
    assign dir_pos = {down, right};
    assign single  = dir_neg ^ dir_pos;

    // Arithmetic shift rounds toward minus infinity; screen v grows downward, mouse dy grows up.
    assign dx_sh     = mouse_dx >>> MOUSE_SHIFT;
    assign dy_sh     = mouse_dy >>> MOUSE_SHIFT;
    assign mdelta[0] = mouse_strobe ? $signed({{3{dx_sh[8]}}, dx_sh}) : 12'sd0;
    assign mdelta[1] = mouse_strobe ? -$signed({{3{dy_sh[8]}}, dy_sh}) : 12'sd0;

    always_comb begin
        for (int ax = 0; ax < 2; ax++) begin
            state_d[ax] = state_q[ax];
            cnt_d[ax]   = cnt_q[ax];
            dir_d[ax]   = dir_q[ax];
            step[ax]    = 12'sd0;
            if (tick) begin
                case (state_q[ax])
                    StIdle: begin
                        if (single[ax]) begin
                            step[ax]    = dir_pos[ax] ? StepSlow : -StepSlow;
                            cnt_d[ax]   = 8'd1;
                            dir_d[ax]   = dir_pos[ax];
                            state_d[ax] = (AccelCnt <= 8'd1) ? StFast : StSlow;
                        end
                    end
                    StSlow, StFast: begin
                        if (!single[ax]) begin
                            state_d[ax] = StIdle;
                            cnt_d[ax]   = 8'd0;
                        end else if (dir_pos[ax] != dir_q[ax]) begin
                            // Reversal restarts at slow speed in the new direction on this tick.
                            step[ax]    = dir_pos[ax] ? StepSlow : -StepSlow;
                            cnt_d[ax]   = 8'd1;
                            dir_d[ax]   = dir_pos[ax];
                            state_d[ax] = (AccelCnt <= 8'd1) ? StFast : StSlow;
                        end else if (state_q[ax] == StSlow) begin
                            step[ax]  = dir_q[ax] ? StepSlow : -StepSlow;
                            cnt_d[ax] = cnt_q[ax] + 8'd1;
                            if ((cnt_q[ax] + 8'd1) >= AccelCnt) begin
                                state_d[ax] = StFast;
                            end
                        end else begin
                            step[ax] = dir_q[ax] ? StepFast : -StepFast;
                            if (cnt_q[ax] != 8'hFF) begin
                                cnt_d[ax] = cnt_q[ax] + 8'd1;
                            end
                        end
                    end
                    default: state_d[ax] = StIdle;
                endcase
            end

            sum[ax] = $signed({2'b00, pos_q[ax]}) + step[ax] + mdelta[ax];
            if (sum[ax] < 12'sd0) begin
                pos_d[ax] = 10'd0;
            end else if (sum[ax] > 12'sd1023) begin
                pos_d[ax] = 10'd1023;
            end else begin
                pos_d[ax] = sum[ax][9:0];
            end

            if (recenter) begin
                pos_d[ax]   = PosCentre;
                state_d[ax] = StIdle;
                cnt_d[ax]   = 8'd0;
            end
        end
        moving_d = (state_d[0] != StIdle) | (state_d[1] != StIdle);
    end

    always_ff @(posedge clock_12) begin
        if (!reset_n) begin
            // A tick_in already high at release must not count as an edge.
            tick_prev_q <= 1'b1;
            moving_q    <= 1'b0;
            for (int ax = 0; ax < 2; ax++) begin
                state_q[ax] <= StIdle;
                cnt_q[ax]   <= 8'd0;
                dir_q[ax]   <= 1'b0;
                pos_q[ax]   <= PosCentre;
            end
        end else begin
            tick_prev_q <= tick_in;
            moving_q    <= moving_d;
            for (int ax = 0; ax < 2; ax++) begin
                state_q[ax] <= state_d[ax];
                cnt_q[ax]   <= cnt_d[ax];
                dir_q[ax]   <= dir_d[ax];
                pos_q[ax]   <= pos_d[ax];
            end
        end
    end

    assign gun_h  = pos_q[0][9:4];
    assign gun_v  = pos_q[1][9:4];
    assign moving = moving_q;

endmodule
